// File: rtl/receive_buff_mc.sv
// receive_buff_mc: tagged receive buffer with per-entry read counts.
// A write allocates the lowest free entry; a read looks up by tag and
// returns the lowest valid matching entry one cycle later. Each matched
// read consumes one unit of the entry's remaining count, and the entry
// frees itself when the count runs out.
// Optional feature macro: RECEIVE_BUFF_OCCUPANCY_EN adds a registered
// occupancy count output.
module receive_buff_mc #(
   parameter int DATA_WIDTH = 8,
   parameter int TAG_WIDTH  = 8,
   parameter int NUM_ENTRY  = 8,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wen,
   input  logic [TAG_WIDTH-1:0]  tag_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [CNT_WIDTH-1:0]  cnt_in,
   input  logic                  ren,
   input  logic [TAG_WIDTH-1:0]  rtag_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  hit,
   output logic                  empty,
   output logic                  full,
`ifdef RECEIVE_BUFF_OCCUPANCY_EN
   output logic [$clog2(NUM_ENTRY+1)-1:0] occupancy,
`endif
   output logic                  overflow
);

   localparam int IDX_W = $clog2(NUM_ENTRY);
   localparam int OCC_W = $clog2(NUM_ENTRY+1);

   logic [NUM_ENTRY-1:0]  r_valid;
   logic [TAG_WIDTH-1:0]  r_tag  [NUM_ENTRY];
   logic [DATA_WIDTH-1:0] r_data [NUM_ENTRY];
   logic [CNT_WIDTH-1:0]  r_cnt  [NUM_ENTRY];

   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_rd_valid;
   logic                  r_hit;
   logic                  r_overflow;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_rd_hit;
   logic [IDX_W-1:0]      w_rd_idx;
   logic                  w_rd_fire;
   logic                  w_rd_last;
   logic                  w_wr_free;
   logic [IDX_W-1:0]      w_wr_idx;
   logic                  w_wr_ok;
   logic [CNT_WIDTH-1:0]  w_wr_cnt;

   assign w_full  = &r_valid;
   assign w_empty = ~|r_valid;

   // Read lookup on pre-edge state: lowest-index valid entry with matching tag.
   always_comb begin
      w_rd_hit = 1'b0;
      w_rd_idx = '0;
      for (int i = NUM_ENTRY-1; i >= 0; i--) begin
         if (r_valid[i] && (r_tag[i] == rtag_in)) begin
            w_rd_hit = 1'b1;
            w_rd_idx = IDX_W'(i);
         end
      end
   end

   // Write allocation: lowest-index invalid entry.
   always_comb begin
      w_wr_free = 1'b0;
      w_wr_idx  = '0;
      for (int i = NUM_ENTRY-1; i >= 0; i--) begin
         if (!r_valid[i]) begin
            w_wr_free = 1'b1;
            w_wr_idx  = IDX_W'(i);
         end
      end
   end

   assign w_rd_fire = ren & w_rd_hit;
   // Count of 1 or less means this read is the last one; guards against underflow.
   assign w_rd_last = (r_cnt[w_rd_idx] <= CNT_WIDTH'(1));
   // Full is sampled at the start of the cycle, so a same-cycle free never rescues a write.
   assign w_wr_ok   = wen & ~w_full & w_wr_free;
   // A zero count would create an entry that can never be consumed; store it as one.
   assign w_wr_cnt  = (cnt_in == '0) ? CNT_WIDTH'(1) : cnt_in;

   // Entry storage: read consumes/frees, write fills a free slot. Both never
   // target the same index since reads hit valid entries and writes only invalid ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < NUM_ENTRY; i++) begin
            r_tag[i]  <= '0;
            r_data[i] <= '0;
            r_cnt[i]  <= '0;
         end
      end else begin
         if (w_rd_fire) begin
            if (w_rd_last) begin
               r_valid[w_rd_idx] <= 1'b0;
               r_cnt[w_rd_idx]   <= '0;
            end else begin
               r_cnt[w_rd_idx]   <= r_cnt[w_rd_idx] - CNT_WIDTH'(1);
            end
         end
         if (w_wr_ok) begin
            r_valid[w_wr_idx] <= 1'b1;
            r_tag[w_wr_idx]   <= tag_in;
            r_data[w_wr_idx]  <= data_in;
            r_cnt[w_wr_idx]   <= w_wr_cnt;
         end
      end
   end

   // Read result register: one-cycle rd_valid pulse, data held on a miss.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_valid <= 1'b0;
         r_hit      <= 1'b0;
         r_data_out <= '0;
      end else begin
         r_rd_valid <= ren;
         r_hit      <= w_rd_fire;
         if (w_rd_fire) begin
            r_data_out <= r_data[w_rd_idx];
         end
      end
   end

   // Sticky overflow flag for writes dropped while full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (wen && w_full) begin
         r_overflow <= 1'b1;
      end
   end

`ifdef RECEIVE_BUFF_OCCUPANCY_EN
   logic [OCC_W-1:0] r_occ;

   // Occupancy tracks valid entries on the same edge the valid bits change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ <= '0;
      end else begin
         r_occ <= r_occ + OCC_W'(w_wr_ok) - OCC_W'(w_rd_fire & w_rd_last);
      end
   end

   assign occupancy = r_occ;
`endif

   assign data_out = r_data_out;
   assign rd_valid = r_rd_valid;
   assign hit      = r_hit;
   assign overflow = r_overflow;
   assign empty    = w_empty;
   assign full     = w_full;

endmodule

// File: tb/tb_receive_buff_mc.sv
// Directed testbench for receive_buff_mc (default parameters).
// Define RECEIVE_BUFF_OCCUPANCY_EN to also exercise the occupancy output.
module tb_receive_buff_mc;

   logic       clk = 1'b0;
   logic       rst;
   logic       wen;
   logic [7:0] tag_in;
   logic [7:0] data_in;
   logic [3:0] cnt_in;
   logic       ren;
   logic [7:0] rtag_in;
   logic [7:0] data_out;
   logic       rd_valid;
   logic       hit;
   logic       empty;
   logic       full;
   logic       overflow;
`ifdef RECEIVE_BUFF_OCCUPANCY_EN
   logic [3:0] occupancy;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   receive_buff_mc dut (
      .clk      (clk),
      .rst      (rst),
      .wen      (wen),
      .tag_in   (tag_in),
      .data_in  (data_in),
      .cnt_in   (cnt_in),
      .ren      (ren),
      .rtag_in  (rtag_in),
      .data_out (data_out),
      .rd_valid (rd_valid),
      .hit      (hit),
      .empty    (empty),
      .full     (full),
`ifdef RECEIVE_BUFF_OCCUPANCY_EN
      .occupancy(occupancy),
`endif
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] t, input logic [7:0] d, input logic [3:0] c);
      wen = 1'b1; tag_in = t; data_in = d; cnt_in = c;
      tick();
      wen = 1'b0;
   endtask

   task automatic rd(input logic [7:0] t);
      ren = 1'b1; rtag_in = t;
      tick();
      ren = 1'b0;
   endtask

   task automatic chk_rd(input string tag, input logic h, input logic [7:0] d);
      chk({tag, "_rv"},   rd_valid, 1'b1);
      chk({tag, "_hit"},  hit, h);
      chk({tag, "_data"}, data_out, d);
   endtask

   initial begin
      rst = 1'b1; wen = 1'b0; ren = 1'b0;
      tag_in = '0; data_in = '0; cnt_in = '0; rtag_in = '0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_rv", rd_valid, 1'b0);
      chk("rst_hit", hit, 1'b0);
      chk("rst_data", data_out, 8'h00);
      chk("rst_ovf", overflow, 1'b0);

      // single-use entry
      wr(8'd5, 8'hA1, 4'd1);
      chk("w5_empty", empty, 1'b0);
`ifdef RECEIVE_BUFF_OCCUPANCY_EN
      chk("w5_occ", occupancy, 4'd1);
`endif
      rd(8'd5);
      chk_rd("r5", 1'b1, 8'hA1);
      chk("r5_empty", empty, 1'b1);
      tick();
      chk("r5_pulse", rd_valid, 1'b0);

      // count of three, back-to-back reads, fourth misses and data holds
      wr(8'd3, 8'h33, 4'd3);
      rd(8'd3); chk_rd("r3a", 1'b1, 8'h33);
      rd(8'd3); chk_rd("r3b", 1'b1, 8'h33);
      rd(8'd3); chk_rd("r3c", 1'b1, 8'h33);
      chk("r3c_empty", empty, 1'b1);
      rd(8'd3); chk_rd("r3d", 1'b0, 8'h33);

      // cnt_in = 0 is stored as one read
      wr(8'd6, 8'h66, 4'd0);
      rd(8'd6); chk_rd("r6a", 1'b1, 8'h66);
      rd(8'd6); chk_rd("r6b", 1'b0, 8'h66);

      // duplicate tags served lowest index first
      wr(8'd4, 8'h11, 4'd1);
      wr(8'd4, 8'h22, 4'd1);
      rd(8'd4); chk_rd("r4a", 1'b1, 8'h11);
      rd(8'd4); chk_rd("r4b", 1'b1, 8'h22);
      chk("r4_empty", empty, 1'b1);

      // fill all entries then overflow
      for (int i = 0; i < 7; i++) wr(8'(i), 8'h80 + 8'(i), 4'd1);
      chk("fill7_full", full, 1'b0);
      wr(8'd7, 8'h87, 4'd1);
      chk("fill8_full", full, 1'b1);
      chk("fill8_ovf", overflow, 1'b0);
`ifdef RECEIVE_BUFF_OCCUPANCY_EN
      chk("fill8_occ", occupancy, 4'd8);
`endif
      wr(8'd9, 8'h99, 4'd1);
      chk("drop_full", full, 1'b1);
      chk("drop_ovf", overflow, 1'b1);
      rd(8'd9); chk_rd("r9a", 1'b0, 8'h22);

      // read frees tag 0 in the same cycle as a write while full: write still dropped
      wen = 1'b1; tag_in = 8'd9; data_in = 8'h99; cnt_in = 4'd1;
      ren = 1'b1; rtag_in = 8'd0;
      tick();
      wen = 1'b0; ren = 1'b0;
      chk_rd("r0", 1'b1, 8'h80);
      chk("r0_full", full, 1'b0);
      chk("r0_ovf", overflow, 1'b1);
      rd(8'd9); chk_rd("r9b", 1'b0, 8'h80);
      rd(8'd1); chk_rd("r1", 1'b1, 8'h81);

      // same-cycle write is invisible to the concurrent read
      wen = 1'b1; tag_in = 8'h0C; data_in = 8'hCC; cnt_in = 4'd1;
      ren = 1'b1; rtag_in = 8'h0C;
      tick();
      wen = 1'b0; ren = 1'b0;
      chk_rd("rCa", 1'b0, 8'h81);
      rd(8'h0C); chk_rd("rCb", 1'b1, 8'hCC);

      // asynchronous reset in the middle of a read
      ren = 1'b1; rtag_in = 8'd2;
      #2 rst = 1'b1;
      #1;
      chk("arst_ovf", overflow, 1'b0);
      chk("arst_empty", empty, 1'b1);
      chk("arst_rv", rd_valid, 1'b0);
      tick();
      rst = 1'b0; ren = 1'b0;
      tick();
      chk("post_rst_rv", rd_valid, 1'b0);
      chk("post_rst_data", data_out, 8'h00);

`ifdef RECEIVE_BUFF_OCCUPANCY_EN
      wr(8'd20, 8'h20, 4'd1);
      wr(8'd21, 8'h21, 4'd2);
      wr(8'd22, 8'h22, 4'd1);
      chk("occ3", occupancy, 4'd3);
      rd(8'd21); chk("occ_dec_only", occupancy, 4'd3);
      rd(8'd20); chk("occ2", occupancy, 4'd2);
      ren = 1'b1; rtag_in = 8'd22;
      #2 rst = 1'b1;
      #1;
      chk("occ_rst", occupancy, 4'd0);
      tick();
      rst = 1'b0; ren = 1'b0;
      tick();
      chk("occ_rst_rv", rd_valid, 1'b0);
      chk("occ_rst_occ", occupancy, 4'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
